// File: rtl/envgen_pkg.sv
// Shared definitions for the ADSR envelope generator.
// Holds the envelope state encoding and the rate-arithmetic guard width.
package envgen_pkg;

  // Envelope state register width.
  localparam int unsigned STATE_W = 3;

  // Extra bits carried on level +/- rate sums so that saturation can be
  // detected before the result is truncated back to the level width.
  localparam int unsigned RATE_GUARD_BITS = 1;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_ATTACK,
    ST_DECAY,
    ST_SUSTAIN,
    ST_RELEASE
  } env_state_e;

endpackage

// File: rtl/env_scale.sv
// Registered amplitude scaler: sample = (waveform * level) >> WAVE_DEPTH.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   waveform   : unsigned oscillator sample
//   level      : unsigned envelope level
//   sample     : scaled result, one clock after waveform/level
module env_scale #(
  parameter int unsigned WAVE_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WAVE_DEPTH-1:0] waveform,
  input  logic [WAVE_DEPTH-1:0] level,
  output logic [WAVE_DEPTH-1:0] sample
);

  localparam int unsigned PROD_W = 2 * WAVE_DEPTH;

  // Full-width unsigned product; keep only the upper half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample <= '0;
    end else begin
      sample <= WAVE_DEPTH'((PROD_W'(waveform) * PROD_W'(level)) >> WAVE_DEPTH);
    end
  end

endmodule

// File: rtl/envelope_gen.sv
// ADSR envelope generator with registered waveform scaling.
// Ports:
//   Clock     : clock, rising edge
//   Reset     : asynchronous active-low reset
//   Tick      : envelope step strobe
//   Gate      : note on/off
//   Attack, Decay, Release : per-Tick level step sizes
//   Sustain   : sustain level
//   Waveform  : unsigned oscillator sample
//   Level     : current envelope level (registered)
//   Sample    : Waveform scaled by Level (registered, 1 clock latency)
//   Active    : high whenever the envelope is not idle (registered)
// Build option: define ENVGEN_RETRIGGER_EN to restart the level from 0 on a
// Gate rise; otherwise attack continues from the current level (legato).
module envelope_gen
  import envgen_pkg::*;
#(
  parameter int unsigned WAVE_DEPTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Tick,
  input  logic                  Gate,
  input  logic [WAVE_DEPTH-1:0] Attack,
  input  logic [WAVE_DEPTH-1:0] Decay,
  input  logic [WAVE_DEPTH-1:0] Release,
  input  logic [WAVE_DEPTH-1:0] Sustain,
  input  logic [WAVE_DEPTH-1:0] Waveform,
  output logic [WAVE_DEPTH-1:0] Level,
  output logic [WAVE_DEPTH-1:0] Sample,
  output logic                  Active
);

  localparam int unsigned SUM_W = WAVE_DEPTH + RATE_GUARD_BITS;
  localparam logic [WAVE_DEPTH-1:0] MAX_LEVEL = '1;

  env_state_e            state, state_n;
  logic [WAVE_DEPTH-1:0] level, level_n;
  logic                  gate_q;
  logic                  active;
  logic                  rise, fall;
  logic [SUM_W-1:0]      attack_sum;
  logic [SUM_W-1:0]      decay_floor;

  // State, level, gate history and activity flag.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state  <= ST_IDLE;
      level  <= '0;
      gate_q <= 1'b0;
      active <= 1'b0;
    end else begin
      state  <= state_n;
      level  <= level_n;
      gate_q <= Gate;
      active <= (state_n != ST_IDLE);
    end
  end

  // Next-state and next-level; Gate edges override any Tick step.
  always_comb begin
    state_n     = state;
    level_n     = level;
    rise        = Gate & ~gate_q;
    fall        = ~Gate & gate_q;
    attack_sum  = SUM_W'(level) + SUM_W'(Attack);
    decay_floor = SUM_W'(Sustain) + SUM_W'(Decay);

    if (rise) begin
      state_n = ST_ATTACK;
`ifdef ENVGEN_RETRIGGER_EN
      level_n = '0;
`else
      level_n = level;
`endif
    end else if (fall) begin
      if (state == ST_ATTACK || state == ST_DECAY || state == ST_SUSTAIN) begin
        state_n = ST_RELEASE;
      end
    end else if (Tick) begin
      unique case (state)
        ST_ATTACK: begin
          // A zero rate holds; the guard bit keeps the sum from wrapping.
          if (Attack != '0) begin
            if (attack_sum >= SUM_W'(MAX_LEVEL)) begin
              state_n = ST_DECAY;
              level_n = MAX_LEVEL;
            end else begin
              level_n = attack_sum[WAVE_DEPTH-1:0];
            end
          end
        end
        ST_DECAY: begin
          if (Decay != '0) begin
            if (SUM_W'(level) <= decay_floor) begin
              state_n = ST_SUSTAIN;
              level_n = Sustain;
            end else begin
              level_n = level - Decay;
            end
          end
        end
        ST_SUSTAIN: begin
          level_n = Sustain;
        end
        ST_RELEASE: begin
          // Release=0 only finishes an envelope that is already at zero.
          if (Release == '0) begin
            if (level == '0) begin
              state_n = ST_IDLE;
            end
          end else if (level <= Release) begin
            state_n = ST_IDLE;
            level_n = '0;
          end else begin
            level_n = level - Release;
          end
        end
        default: begin
          state_n = state;
          level_n = level;
        end
      endcase
    end
  end

  env_scale #(
    .WAVE_DEPTH(WAVE_DEPTH)
  ) u_scale (
    .clk     (Clock),
    .rst_n   (Reset),
    .waveform(Waveform),
    .level   (level),
    .sample  (Sample)
  );

  assign Level  = level;
  assign Active = active;

endmodule

// File: doc/envelope_gen.md
ENVELOPE_GEN -- requirements
Module: envelope_gen

Interface
REQ-001 SHALL have parameter WAVE_DEPTH, default 8, giving the sample and level width; MAX = 2^WAVE_DEPTH-1.
REQ-002 SHALL have port Clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Tick, input, 1 bit: envelope step strobe; level changes only on cycles where Tick=1.
REQ-005 SHALL have port Gate, input, 1 bit: note on (1) or off (0).
REQ-006 SHALL have ports Attack, Decay, Release, input, WAVE_DEPTH bits each: per-Tick level step sizes.
REQ-007 SHALL have port Sustain, input, WAVE_DEPTH bits: the sustain level.
REQ-008 SHALL have port Waveform, input, WAVE_DEPTH bits: an unsigned oscillator sample (0..MAX) from the upstream wave generator.
REQ-009 SHALL have port Level, output, WAVE_DEPTH bits: the current envelope level.
REQ-010 SHALL have port Sample, output, WAVE_DEPTH bits: the Waveform scaled by Level.
REQ-011 SHALL have port Active, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-012 SHALL implement the states IDLE, ATTACK, DECAY, SUSTAIN and RELEASE.
REQ-013 SHALL register Gate every cycle; a rise is Gate=1 with the previous Gate=0, and a fall is Gate=0 with the previous Gate=1.
REQ-014 SHALL enter ATTACK on a Gate rise in any state, evaluated every cycle regardless of Tick.
REQ-015 SHALL enter RELEASE on a Gate fall in ATTACK, DECAY or SUSTAIN, evaluated every cycle regardless of Tick.
REQ-016 SHALL, in any cycle containing a Gate edge, hold Level unchanged even if Tick=1; the edge takes precedence.
REQ-017 SHALL, in ATTACK with Tick=1, go to DECAY with Level=MAX if Level+Attack >= MAX, otherwise set Level=Level+Attack; the sum uses WAVE_DEPTH+1 bits, so there is no wrap.
REQ-018 SHALL, in DECAY with Tick=1, go to SUSTAIN with Level=Sustain if Level <= Sustain+Decay, otherwise set Level=Level-Decay.
REQ-019 SHALL, in SUSTAIN with Tick=1, load Level=Sustain, tracking live changes to Sustain.
REQ-020 SHALL, in RELEASE with Tick=1, go to IDLE with Level=0 if Level <= Release, otherwise set Level=Level-Release.
REQ-021 SHALL hold Level unchanged in IDLE, with Level=0 there.
REQ-022 SHALL treat a rate of 0 as a hold: Level is unchanged and no transition occurs, except that Release=0 from Level=0 goes to IDLE.
REQ-023 SHALL register Sample = (Waveform*Level)>>WAVE_DEPTH, an unsigned full-width product, with exactly one Clock of latency from Waveform and Level.
REQ-024 SHALL drive Level and Active directly from registers, with zero cycles of added latency.

Reset
REQ-025 SHALL, while Reset=0, force state IDLE, Level=0, Sample=0, Active=0 and the registered Gate=0, independent of Clock.
REQ-026 SHALL, on Reset assertion mid-envelope, abandon the envelope immediately; after release, a Gate held high produces a rise on the first Clock.

Configuration
REQ-027 SHALL provide the macro ENVGEN_RETRIGGER_EN; when it is defined, a Gate rise SHALL also load Level=0 (hard retrigger).
REQ-028 SHALL, without ENVGEN_RETRIGGER_EN, keep the current Level on a Gate rise so that ATTACK continues from it (legato).

Structure
REQ-029 SHALL place the state enum (3-bit encoding) and the rate-saturation helper constants in shared package envgen_pkg.
REQ-030 SHALL place the registered multiply of REQ-023 in one sub-module, env_scale, parameterised by WAVE_DEPTH.

Verification (WAVE_DEPTH=8, Tick every cycle unless stated)
REQ-031 SHALL cover full ADSR: Attack=64, Decay=32, Sustain=128, Release=16, Gate held for 20 cycles, then cleared.
- Required Level: 64, 128, 192, 255, 223, 191, 159, 128, held at 128.
- After the fall, Level drops 16 per Tick to 0, then IDLE with Active=0.
REQ-032 SHALL cover saturation: Attack=200 from Level=100 -> Level=255 and DECAY on that Tick, with no wrap to 44.
REQ-033 SHALL cover a mid-operation Gate fall: Gate falls in ATTACK at Level=128 on a cycle with Tick=1.
- Required: Level stays 128 that cycle, state is RELEASE, and the next Tick gives 128-Release.
REQ-034 SHALL cover retrigger: a Gate rise during RELEASE at Level=80.
- With ENVGEN_RETRIGGER_EN: Level=0 and then 64.
- Without it: Level=80 and then 144.
REQ-035 SHALL cover scaling: Waveform=255 and Level=128 -> Sample=127 one cycle later; Level=0 -> Sample=0.
REQ-036 SHALL cover asynchronous reset: assert Reset in SUSTAIN between Clock edges.
- Required: Level, Sample and Active read 0 before the next edge.
- After release with Gate=1: ATTACK begins on the first Clock.
